// File: rtl/rf_write_arbiter.sv
// Write-port arbiter for the decode-stage register file: primary writeback vs. an auxiliary
// valid/ready writer with starvation guard. Define RF_CLEAR_ON_RESET_EN for a post-reset clear sweep.
module rf_write_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        wb_we_i,
    input  logic [4:0]  wb_rd_i,
    input  logic [31:0] wb_data_i,
    output logic        wb_stall_o,
    input  logic        aux_valid_i,
    input  logic [4:0]  aux_rd_i,
    input  logic [31:0] aux_data_i,
    output logic        aux_ready_o,
    output logic        rf_we_o,
    output logic [4:0]  rf_waddr_o,
    output logic [31:0] rf_wdata_o,
    output logic        init_done_o
);

    localparam logic [3:0] StarveMax = 4'(STARVE_LIMIT);

    logic        p_req;
    logic        grant_wb;
    logic        grant_aux;
    logic        in_init;
    logic        sweep_last;
    logic [4:0]  sweep_addr;
    logic [3:0]  starve_q, starve_d;
    logic        rf_we_q, rf_we_d;
    logic [4:0]  rf_waddr_q, rf_waddr_d;
    logic [31:0] rf_wdata_q, rf_wdata_d;
    logic        init_done_q, init_done_d;

    assign p_req = wb_we_i && (wb_rd_i != 5'd0);

`ifdef RF_CLEAR_ON_RESET_EN
    typedef enum logic [0:0] {StInit, StRun} state_e;

    state_e     state_q, state_d;
    logic [4:0] idx_q, idx_d;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= StInit;
            idx_q   <= 5'd0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        if (state_q == StInit) begin
            idx_d = idx_q + 5'd1;
            if (idx_q == 5'd31) begin
                state_d = StRun;
            end
        end
    end

    assign in_init    = (state_q == StInit);
    assign sweep_last = in_init && (idx_q == 5'd31);
    assign sweep_addr = idx_q;
`else
    assign in_init    = 1'b0;
    assign sweep_last = 1'b0;
    assign sweep_addr = 5'd0;
`endif

    // Fixed-priority arbitration; the starvation override sits above the primary.
    always_comb begin
        grant_wb    = 1'b0;
        grant_aux   = 1'b0;
        wb_stall_o  = 1'b1;
        aux_ready_o = 1'b0;
        if (rst_ni && !in_init) begin
            if (aux_valid_i && (starve_q == StarveMax)) begin
                grant_aux   = 1'b1;
                aux_ready_o = 1'b1;
                wb_stall_o  = p_req;
            end else if (p_req) begin
                grant_wb    = 1'b1;
                wb_stall_o  = 1'b0;
            end else begin
                grant_aux   = aux_valid_i;
                aux_ready_o = 1'b1;
                wb_stall_o  = 1'b0;
            end
        end
    end

    always_comb begin
        rf_we_d    = 1'b0;
        rf_waddr_d = rf_waddr_q;
        rf_wdata_d = rf_wdata_q;
        if (in_init) begin
            rf_we_d    = 1'b1;
            rf_waddr_d = sweep_addr;
            rf_wdata_d = 32'd0;
        end else if (grant_wb) begin
            rf_we_d    = 1'b1;
            rf_waddr_d = wb_rd_i;
            rf_wdata_d = wb_data_i;
        end else if (grant_aux) begin
            rf_we_d    = (aux_rd_i != 5'd0);
            rf_waddr_d = aux_rd_i;
            rf_wdata_d = aux_data_i;
        end
    end

    always_comb begin
        starve_d = starve_q;
        if (!aux_valid_i || aux_ready_o) begin
            starve_d = 4'd0;
        end else if (starve_q < StarveMax) begin
            starve_d = starve_q + 4'd1;
        end
    end

`ifdef RF_CLEAR_ON_RESET_EN
    assign init_done_d = init_done_q || sweep_last;
`else
    assign init_done_d = 1'b1;
`endif

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rf_we_q     <= 1'b0;
            rf_waddr_q  <= 5'd0;
            rf_wdata_q  <= 32'd0;
            init_done_q <= 1'b0;
            starve_q    <= 4'd0;
        end else begin
            rf_we_q     <= rf_we_d;
            rf_waddr_q  <= rf_waddr_d;
            rf_wdata_q  <= rf_wdata_d;
            init_done_q <= init_done_d;
            starve_q    <= starve_d;
        end
    end

    assign rf_we_o     = rf_we_q;
    assign rf_waddr_o  = rf_waddr_q;
    assign rf_wdata_o  = rf_wdata_q;
    assign init_done_o = init_done_q;

endmodule

// File: doc/rf_write_arbiter.md
# rf_write_arbiter

- Owns the single write port (WE3/A3/WD3) of the decode-stage register file.
- Shares that port between two requesters:
  - the pipeline writeback stage (primary);
  - an auxiliary writer with a valid/ready handshake, e.g. a multi-cycle divide or load-return unit.
- Optionally sequences a clear of all 32 registers after reset.
- Guarantees the auxiliary writer cannot be starved.
- Write-port outputs are registered, so the register file captures them on the negedge of the cycle they are driven.

## Interface
Parameters:
- STARVE_LIMIT, 4 — cycles aux_valid may be held off by the primary before the primary is stalled; legal range 1..15.

Ports:
- clk  in  1  — rising-edge clock.
- rst_n  in  1  — reset; synchronous and active-low.
- wb_we  in  1  — primary writeback request.
- wb_rd  in  5  — primary destination register.
- wb_data  in  32  — primary write data.
- wb_stall  out  1  — primary not accepted this cycle; the pipeline holds wb_* stable.
- aux_valid  in  1  — auxiliary request.
- aux_rd  in  5  — auxiliary destination register.
- aux_data  in  32  — auxiliary write data.
- aux_ready  out  1  — auxiliary request accepted this cycle.
- rf_we  out  1  — register file write enable (to WE3).
- rf_waddr  out  5  — register file write address (to A3).
- rf_wdata  out  32  — register file write data (to WD3).
- init_done  out  1  — high once the arbiter is accepting requests.

## Operation
- Effective requests:
  - p = wb_we && wb_rd != 0.
  - a = aux_valid.
- x0 handling:
  - wb_we with wb_rd == 0 is a no-op and never stalls.
  - An aux request with aux_rd == 0 is accepted (aux_ready=1) but produces rf_we=0.
- States:
  - INIT: clear sweep; present only with the macro.
  - RUN.
- INIT behaviour:
  - 5-bit counter idx runs 0..31, one write per cycle: rf_we=1, rf_waddr=idx, rf_wdata=0.
  - wb_stall=1 and aux_ready=0 throughout.
  - After idx=31 is issued, go to RUN and set init_done=1.
- RUN arbitration, evaluated combinationally each cycle with fixed priority:
  1. a && starve==STARVE_LIMIT: grant aux, aux_ready=1, wb_stall=p.
  2. p: grant primary, wb_stall=0, aux_ready=0.
  3. Otherwise: aux_ready=1, grant aux if a.
- Granted request's rd and data are registered into rf_waddr/rf_wdata.
- rf_we is registered as 1, except for an aux grant with aux_rd=0, which registers rf_we=0.
- With no grant, the next rf_we is 0; rf_waddr and rf_wdata hold their values.
- Starvation counter starve (4 bits):
  - Increments when a && !aux_ready.
  - Clears when aux is accepted or when aux_valid=0.
  - Saturates at STARVE_LIMIT.
- Ordering: when aux is forced ahead of a stalled primary writing the same rd, the primary's write lands one cycle later and wins. Hazard/forwarding logic owns any read-after-write visibility.

## Timing
- Reset, applied synchronously on a clk edge with rst_n=0:
  - rf_we=0, rf_waddr=0, rf_wdata=0, init_done=0, starve=0, idx=0.
  - State goes to INIT with the macro, RUN without it.
  - While rst_n=0: wb_stall=1, aux_ready=0.
- Reset mid-operation, including mid-sweep: any registered write in flight is dropped, the sweep restarts from idx=0, and the starvation count is lost.
- Latency: a request granted in cycle N appears on rf_* in cycle N+1. The register file captures it on the negedge of cycle N+1.
- Sweep: 32 cycles of rf_we=1 immediately after reset release; init_done rises in the cycle after the write to address 31.
- Without the macro, init_done rises on the first clk edge with rst_n=1.
- Handshakes:
  - aux_ready is combinational from aux_valid and the state.
  - aux_valid may drop only after acceptance.
  - wb_stall is combinational from wb_we, wb_rd and the state.
- Throughput: one write per cycle. Under continuous p && a, aux gets one slot per STARVE_LIMIT+1 cycles.

## Configuration
- RF_CLEAR_ON_RESET_EN defined:
  - INIT state and idx counter are built.
  - Every register, including x0, reads 0 after the sweep.
- RF_CLEAR_ON_RESET_EN undefined:
  - No INIT state; reset goes straight to RUN.
  - Register contents other than x0 are undefined until written.
  - x0 is never written, because rd==0 writes are suppressed.

## Test plan
- Reset and sweep (macro on): release rst_n -> rf_we=1 for exactly 32 cycles, rf_waddr 0..31, rf_wdata=0. Then init_done=1, and reads of x5 and x31 return 0.
- Primary only: wb_we=1, wb_rd=7, wb_data=32'hDEADBEEF in cycle N -> wb_stall=0. Cycle N+1 has rf_we=1, rf_waddr=7, rf_wdata=32'hDEADBEEF; RD of x7 equals 32'hDEADBEEF after the negedge.
- Idle port: wb_we=0 with aux_valid=1, aux_rd=3, aux_data=5 -> aux_ready=1 the same cycle. Next cycle rf_we=1, rf_waddr=3.
- Starvation, STARVE_LIMIT=4: p held high (rd=1) and aux_valid=1 (rd=2) continuously -> aux_ready=0 for 4 cycles. In the 5th cycle aux_ready=1 and wb_stall=1; in the 6th rf_waddr=2, then rf_waddr=1.
- x0 suppression: wb_we=1, wb_rd=0 with aux_valid=1 -> wb_stall=0, aux_ready=1. An aux write with aux_rd=0 gives aux_ready=1 and rf_we=0 next cycle.
- Mid-sweep reset: assert rst_n=0 at sweep idx=12 for one cycle -> rf_we=0 and init_done=0 during reset. The sweep restarts at rf_waddr=0 and completes all 32 writes.
